// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage initiator for the data SRAM port.
//
// Accepts one op per handshake from execute. Aligned loads/stores issue a single word-aligned
// SRAM request with byte strobes and wait for the ack. Load data comes back right-aligned and
// unextended; writeback does the sign/zero extension. Non-memory and misaligned ops skip the
// SRAM entirely and go straight to the response beat.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_in_* / o_in_ready     op handshake from execute (valid/ready, all fields registered on accept)
//   o_sram_* / i_sram_*     SRAM request (held until ack) and ack/read data
//   o_out_* / i_out_ready   result beat to writeback (load data, tag, fault flags)
//
// Configuration macro: LSU_TIMEOUT_EN
//   defined   - a REQ that sees no ack for MAX_WAIT cycles is abandoned with o_out_bus_error=1
//   undefined - REQ waits indefinitely and o_out_bus_error is tied 0
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 64,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_in_is_load,
  input  logic                  i_in_is_store,
  input  logic [2:0]            i_in_funct3,
  input  logic [ADDR_WIDTH-1:0] i_in_address,
  input  logic [DATA_WIDTH-1:0] i_in_store_data,
  input  logic [TAG_WIDTH-1:0]  i_in_tag,
  output logic                  o_sram_req,
  output logic                  o_sram_we,
  output logic [ADDR_WIDTH-3:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  output logic [3:0]            o_sram_wstrb,
  input  logic                  i_sram_ack,
  input  logic [DATA_WIDTH-1:0] i_sram_rdata,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_load_data,
  output logic [TAG_WIDTH-1:0]  o_out_tag,
  output logic                  o_out_misaligned,
  output logic                  o_out_bus_error
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_is_load;
  logic                  r_is_store;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_store_data;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_misaligned;

  logic                  w_accept;
  logic                  w_mem;
  logic                  w_misaligned;
  logic                  w_go_req;
  logic                  w_timeout;
  logic                  w_in_req;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [3:0]            w_wstrb;
  logic [DATA_WIDTH-1:0] w_load_shift;

  // funct3[2] only selects sign/zero extension, which is writeback's job.
  logic w_unused_funct3;
  assign w_unused_funct3 = i_in_funct3[2];

  assign w_in_req   = (r_state == StReq);
  assign o_in_ready = (r_state == StIdle) | ((r_state == StResp) & i_out_ready);
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_mem      = i_in_is_load | i_in_is_store;

  // Size encoding 11 is not a legal access width and faults like a misalignment.
  always_comb begin
    w_misaligned = 1'b0;
    case (i_in_funct3[1:0])
      2'b01:   w_misaligned = i_in_address[0];
      2'b10:   w_misaligned = (i_in_address[1:0] != 2'b00);
      2'b11:   w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
    w_misaligned = w_misaligned & w_mem;
  end

  assign w_go_req = w_mem & ~w_misaligned;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_go_req ? StReq : StResp;
      end
      StReq: begin
        if (i_sram_ack || w_timeout) w_state_next = StResp;
      end
      StResp: begin
        if (i_out_ready) begin
          if (i_in_valid) w_state_next = w_go_req ? StReq : StResp;
          else            w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Lane replication lets the SRAM take data from any lane without a shifter on its side.
  always_comb begin
    w_wdata = r_store_data;
    w_wstrb = 4'hF;
    case (r_size)
      2'b00: begin
        w_wdata = {(DATA_WIDTH / 8){r_store_data[7:0]}};
        w_wstrb = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_wdata = {(DATA_WIDTH / 16){r_store_data[15:0]}};
        w_wstrb = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_wdata = r_store_data;
        w_wstrb = 4'hF;
      end
    endcase
  end

  // Word accesses are always aligned here, so the shift is zero for them.
  assign w_load_shift = i_sram_rdata >> {r_addr[1:0], 3'b000};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_is_load    <= 1'b0;
      r_is_store   <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_store_data <= '0;
      r_tag        <= '0;
      r_load_data  <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_is_load    <= i_in_is_load;
        r_is_store   <= i_in_is_store;
        r_size       <= i_in_funct3[1:0];
        r_addr       <= i_in_address;
        r_store_data <= i_in_store_data;
        r_tag        <= i_in_tag;
        r_load_data  <= '0;
        r_misaligned <= w_misaligned;
      end else if (w_in_req && i_sram_ack && r_is_load && !r_is_store) begin
        r_load_data <= w_load_shift;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned WaitW = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);

  logic [WaitW-1:0] r_wait;
  logic             r_bus_error;

  // Fires in the MAX_WAIT-th REQ cycle that still has no ack.
  assign w_timeout = w_in_req & ~i_sram_ack & (r_wait == WaitW'(MAX_WAIT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wait      <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wait      <= '0;
        r_bus_error <= 1'b0;
      end else if (w_in_req && !i_sram_ack) begin
        r_wait <= r_wait + 1'b1;
        if (w_timeout) r_bus_error <= 1'b1;
      end
    end
  end

  assign o_out_bus_error = (r_state == StResp) & r_bus_error;
`else
  logic w_unused_max_wait;
  assign w_unused_max_wait = |MAX_WAIT;
  assign w_timeout         = 1'b0;
  assign o_out_bus_error   = 1'b0;
`endif

  assign o_sram_req       = w_in_req;
  assign o_sram_we        = w_in_req & r_is_store;
  assign o_sram_addr      = w_in_req ? r_addr[ADDR_WIDTH-1:2] : '0;
  assign o_sram_wdata     = (w_in_req & r_is_store) ? w_wdata : '0;
  assign o_sram_wstrb     = (w_in_req & r_is_store) ? w_wstrb : 4'h0;

  assign o_out_valid      = (r_state == StResp);
  assign o_out_load_data  = (r_state == StResp) ? r_load_data : '0;
  assign o_out_misaligned = (r_state == StResp) & r_misaligned;
  assign o_out_tag        = r_tag;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Expected result beats are pushed to a scoreboard
// queue when an op is driven and popped when the unit presents o_out_valid.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_address;
  logic [31:0] in_store_data;
  logic [63:0] in_tag;
  logic        sram_req;
  logic        sram_we;
  logic [29:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_ack;
  logic [31:0] sram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_load_data;
  logic [63:0] out_tag;
  logic        out_misaligned;
  logic        out_bus_error;

  typedef struct {
    logic [63:0] tag;
    logic [31:0] data;
    logic [31:0] mask;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  load_store_unit dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_in_is_load    (in_is_load),
    .i_in_is_store   (in_is_store),
    .i_in_funct3     (in_funct3),
    .i_in_address    (in_address),
    .i_in_store_data (in_store_data),
    .i_in_tag        (in_tag),
    .o_sram_req      (sram_req),
    .o_sram_we       (sram_we),
    .o_sram_addr     (sram_addr),
    .o_sram_wdata    (sram_wdata),
    .o_sram_wstrb    (sram_wstrb),
    .i_sram_ack      (sram_ack),
    .i_sram_rdata    (sram_rdata),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_load_data (out_load_data),
    .o_out_tag       (out_tag),
    .o_out_misaligned(out_misaligned),
    .o_out_bus_error (out_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents an op at a negedge, waits (bounded) for in_ready, returns just after the accept edge.
  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [63:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_address = addr; in_store_data = sd; in_tag = tag; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL accept_bound: in_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (sram_req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b want 0", sram_req); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_tag !== 64'h0) begin n_errors++; $display("FAIL rst_tag: got %h want 0", out_tag); end
    n_checks++; if (out_load_data !== 32'h0) begin n_errors++; $display("FAIL rst_data: got %h want 0", out_load_data); end
    n_checks++; if (out_misaligned !== 1'b0 || out_bus_error !== 1'b0) begin
      n_errors++; $display("FAIL rst_flags: got mis=%b berr=%b want 0 0", out_misaligned, out_bus_error);
    end
    n_checks++; if (sram_we !== 1'b0 || sram_wstrb !== 4'h0) begin
      n_errors++; $display("FAIL rst_we: got we=%b strb=%h want 0 0", sram_we, sram_wstrb);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // LBU at 0x1003, ack held off for three REQ cycles: result beat on the 5th edge counting accept.
  task automatic test_lbu();
    exp_t e;
    sb.push_back('{tag: 64'h1111, data: 32'h0000_00AA, mask: 32'h0000_00FF, mis: 1'b0, berr: 1'b0});
    drive_op(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 64'h1111);
    @(negedge clk);
    n_checks++; if (sram_req !== 1'b1) begin n_errors++; $display("FAIL lbu_req: got %b want 1", sram_req); end
    n_checks++; if (sram_addr !== 30'h400) begin n_errors++; $display("FAIL lbu_addr: got %h want 400", sram_addr); end
    n_checks++; if (sram_we !== 1'b0 || sram_wstrb !== 4'h0) begin
      n_errors++; $display("FAIL lbu_we: got we=%b strb=%h want 0 0", sram_we, sram_wstrb);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || sram_req !== 1'b1) begin
      n_errors++; $display("FAIL lbu_wait: got valid=%b req=%b want 0 1", out_valid, sram_req);
    end
    sram_ack = 1'b1; sram_rdata = 32'hAABB_CCDD;
    @(posedge clk);
    #1 sram_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL lbu_latency: valid got %b want 1", out_valid); end
    n_checks++; if (sram_req !== 1'b0) begin n_errors++; $display("FAIL lbu_req_drop: got %b want 0", sram_req); end
    e = sb.pop_front();
    n_checks++; if ((out_load_data & e.mask) !== e.data) begin
      n_errors++; $display("FAIL lbu_data: got %h want %h", out_load_data & e.mask, e.data);
    end
    n_checks++; if (out_tag !== e.tag) begin n_errors++; $display("FAIL lbu_tag: got %h want %h", out_tag, e.tag); end
  endtask

  task automatic test_store_sh();
    exp_t e;
    sb.push_back('{tag: 64'h2222, data: 32'h0, mask: 32'hFFFF_FFFF, mis: 1'b0, berr: 1'b0});
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 64'h2222);
    @(negedge clk);
    n_checks++; if (sram_req !== 1'b1 || sram_we !== 1'b1) begin
      n_errors++; $display("FAIL sh_req: got req=%b we=%b want 1 1", sram_req, sram_we);
    end
    n_checks++; if (sram_wdata !== 32'hBEEF_BEEF) begin n_errors++; $display("FAIL sh_wdata: got %h want beefbeef", sram_wdata); end
    n_checks++; if (sram_wstrb !== 4'b1100) begin n_errors++; $display("FAIL sh_wstrb: got %b want 1100", sram_wstrb); end
    n_checks++; if (sram_addr !== 30'h800) begin n_errors++; $display("FAIL sh_addr: got %h want 800", sram_addr); end
    sram_ack = 1'b1; sram_rdata = 32'h1234_5678;
    @(posedge clk);
    #1 sram_ack = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL sh_valid: got %b want 1", out_valid); end
    n_checks++; if (out_load_data !== e.data) begin n_errors++; $display("FAIL sh_data: got %h want %h", out_load_data, e.data); end
    n_checks++; if (out_tag !== e.tag) begin n_errors++; $display("FAIL sh_tag: got %h want %h", out_tag, e.tag); end
  endtask

  task automatic test_load_sweep();
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
    logic [1:0]  offs[6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0};
    logic [31:0] rd, m;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      rd = $urandom;
      m  = (f3s[i][1:0] == 2'b00) ? 32'hFF : (f3s[i][1:0] == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
      sb.push_back('{tag: 64'h3000 + 64'(i), data: (rd >> (8 * offs[i])) & m, mask: m, mis: 1'b0, berr: 1'b0});
      drive_op(1'b1, 1'b0, f3s[i], 32'h0000_0100 + 32'(offs[i]), 32'h0, 64'h3000 + 64'(i));
      @(negedge clk);
      sram_ack = 1'b1; sram_rdata = rd;
      @(posedge clk);
      #1 sram_ack = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (out_valid !== 1'b1 || (out_load_data & e.mask) !== e.data || out_tag !== e.tag) begin
        n_errors++; $display("FAIL load_sweep[%0d]: got v=%b d=%h t=%h want 1 %h %h", i, out_valid,
                             out_load_data & e.mask, out_tag, e.data, e.tag);
      end
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] sd;
    exp_t        e;
    for (int o = 0; o < 5; o++) begin
      sd = $urandom;
      sb.push_back('{tag: 64'h4000 + 64'(o), data: 32'h0, mask: 32'hFFFF_FFFF, mis: 1'b0, berr: 1'b0});
      if (o < 4) drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0200 + 32'(o), sd, 64'h4000 + 64'(o));
      else       drive_op(1'b0, 1'b1, 3'b010, 32'h0000_0200, sd, 64'h4000 + 64'(o));
      @(negedge clk);
      if (o < 4) begin
        n_checks++; if (sram_wstrb !== (4'b0001 << o) || sram_wdata !== {4{sd[7:0]}}) begin
          n_errors++; $display("FAIL sb_lane[%0d]: got strb=%b wd=%h want %b %h", o, sram_wstrb,
                               sram_wdata, 4'b0001 << o, {4{sd[7:0]}});
        end
      end else begin
        n_checks++; if (sram_wstrb !== 4'hF || sram_wdata !== sd) begin
          n_errors++; $display("FAIL sw_lane: got strb=%b wd=%h want 1111 %h", sram_wstrb, sram_wdata, sd);
        end
      end
      sram_ack = 1'b1;
      @(posedge clk);
      #1 sram_ack = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (out_valid !== 1'b1 || out_load_data !== e.data || out_tag !== e.tag) begin
        n_errors++; $display("FAIL store_beat[%0d]: got v=%b d=%h t=%h want 1 %h %h", o, out_valid,
                             out_load_data, out_tag, e.data, e.tag);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        lds [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b101, 3'b001, 3'b011};
    logic [31:0] ads [4] = '{32'h3001, 32'h0011, 32'h0013, 32'h0020};
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{tag: 64'h5000 + 64'(i), data: 32'h0, mask: 32'hFFFF_FFFF, mis: 1'b1, berr: 1'b0});
      drive_op(lds[i], ~lds[i], f3s[i], ads[i], 32'hFFFF_FFFF, 64'h5000 + 64'(i));
      @(negedge clk);
      e = sb.pop_front();
      n_checks++; if (sram_req !== 1'b0) begin n_errors++; $display("FAIL mis_req[%0d]: got %b want 0", i, sram_req); end
      n_checks++; if (out_valid !== 1'b1 || out_misaligned !== e.mis || out_load_data !== e.data
                      || out_tag !== e.tag) begin
        n_errors++; $display("FAIL mis_beat[%0d]: got v=%b m=%b d=%h t=%h want 1 %b %h %h", i, out_valid,
                             out_misaligned, out_load_data, out_tag, e.mis, e.data, e.tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{tag: 64'hA0A0, data: 32'h0, mask: 32'hFFFF_FFFF, mis: 1'b0, berr: 1'b0});
    sb.push_back('{tag: 64'hB0B0, data: 32'h0, mask: 32'hFFFF_FFFF, mis: 1'b0, berr: 1'b0});
    out_ready = 1'b1;
    @(negedge clk);
    in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b010; in_address = 32'h1;
    in_tag = 64'hA0A0; in_valid = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_tag = 64'hB0B0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== e.tag) begin
      n_errors++; $display("FAIL b2b_first: got r=%b v=%b t=%h want 1 1 %h", in_ready, out_valid, out_tag, e.tag);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if (out_valid !== 1'b1 || out_tag !== e.tag || out_misaligned !== e.mis) begin
      n_errors++; $display("FAIL b2b_second: got v=%b t=%h m=%b want 1 %h %b", out_valid, out_tag,
                           out_misaligned, e.tag, e.mis);
    end
  endtask

  task automatic test_reset_inflight();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 64'h6666);
    @(negedge clk);
    n_checks++; if (sram_req !== 1'b1) begin n_errors++; $display("FAIL rif_req: got %b want 1", sram_req); end
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; sram_ack = 1'b1; sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (sram_req !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rif_drop: got req=%b v=%b want 0 0", sram_req, out_valid);
    end
    @(posedge clk);
    #1 sram_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (sram_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL rif_idle: got req=%b v=%b r=%b want 0 0 1", sram_req, out_valid, in_ready);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int   n;
    exp_t e;
    sb.push_back('{tag: 64'h7777, data: 32'h0, mask: 32'hFFFF_FFFF, mis: 1'b0, berr: 1'b1});
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 64'h7777);
    n = 0;
    @(negedge clk);
    while (sram_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    n_checks++; if (n != 15) begin n_errors++; $display("FAIL to_cycles: got %0d want 15", n); end
    n_checks++; if (out_valid !== 1'b1 || out_bus_error !== e.berr || out_load_data !== e.data) begin
      n_errors++; $display("FAIL to_beat: got v=%b be=%b d=%h want 1 %b %h", out_valid, out_bus_error,
                           out_load_data, e.berr, e.data);
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
    in_address = 32'h0; in_store_data = 32'h0; in_tag = 64'h0;
    sram_ack = 1'b0; sram_rdata = 32'h0; out_ready = 1'b1;
    test_reset();
    test_lbu();
    test_store_sh();
    test_load_sweep();
    test_store_lanes();
    test_misaligned();
    test_back_to_back();
    test_reset_inflight();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (sb.size() != 0) begin n_errors++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
